// File: rtl/pong_tick_sched_if.sv
// Request/acknowledge bundle between the tick scheduler (master) and the
// shared object-update engine (slave).
interface pong_tick_sched_if;
    logic ball_req;
    logic ball_ack;
    logic pad_req;
    logic pad_ack;

    modport master (output ball_req, output pad_req, input ball_ack, input pad_ack);
    modport slave  (input ball_req, input pad_req, output ball_ack, output pad_ack);
endinterface

// File: rtl/pong_tick_sched.sv
// Pong tick scheduler: programmable ball/paddle tick dividers arbitrated onto
// one object-update engine, with ball speed-up driven by paddle hits.
module pong_tick_sched #(
    parameter int unsigned BASE_DIV       = 800000,
    parameter int unsigned DIV_STEP       = 50000,
    parameter int unsigned MIN_DIV        = 200000,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned PADDLE_DIV     = 400000,
    parameter int unsigned TIMEOUT        = 1023
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              run,
    input  logic              hit,
    input  logic              miss,
    pong_tick_sched_if.master eng,
    output logic              busy,
    output logic [3:0]        speed_level,
    output logic [27:0]       cur_div,
    output logic [7:0]        overrun_cnt,
    output logic              timeout_err
);

    localparam int unsigned       TMO_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned       HC_W     = $clog2(HITS_PER_LEVEL + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [HC_W-1:0]   HC_LAST  = HC_W'(HITS_PER_LEVEL - 1);
    localparam logic [27:0]       PAD_LAST = 28'(PADDLE_DIV - 1);

    typedef enum logic [1:0] {IDLE, BALL_WAIT, PAD_WAIT} state_t;

    function automatic logic [31:0] level_reduction(input logic [3:0] lvl);
        return 32'(lvl) * DIV_STEP;
    endfunction

    function automatic logic [27:0] div_for_level(input logic [3:0] lvl);
        if (level_reduction(lvl) + MIN_DIV >= BASE_DIV)
            return 28'(MIN_DIV);
        return 28'(BASE_DIV - level_reduction(lvl));
    endfunction

    function automatic logic at_speed_cap(input logic [3:0] lvl);
        return (lvl == 4'd15) || (level_reduction(lvl) + MIN_DIV >= BASE_DIV);
    endfunction

    state_t            state_q;
    logic              ball_req_q, pad_req_q, timeout_err_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [27:0]       ball_cnt_q, ball_cnt_d, pad_cnt_q, pad_cnt_d;
    logic              ball_pend_q, ball_pend_d, pad_pend_q, pad_pend_d;
    logic [7:0]        overrun_q, overrun_d;
    logic [HC_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [3:0]        level_q, level_d;
    logic [27:0]       cur_div_q, cur_div_d;
    logic              ball_grant, pad_grant, ball_wrap, pad_wrap;
    logic              ball_tick, pad_tick, ball_ovr, pad_ovr;
    logic [8:0]        ovr_sum;

    always_comb begin
        ball_grant = (state_q == IDLE) && ball_pend_q;
        pad_grant  = (state_q == IDLE) && !ball_pend_q && pad_pend_q;
        // >= rather than == so a shrinking divisor below the count wraps at once
        ball_wrap  = ball_cnt_q >= (cur_div_q - 28'd1);
        pad_wrap   = pad_cnt_q >= PAD_LAST;
        ball_tick  = run && ball_wrap;
        pad_tick   = run && pad_wrap;
        ball_cnt_d = '0;
        pad_cnt_d  = '0;
        if (run) begin
            ball_cnt_d = ball_wrap ? 28'd0 : ball_cnt_q + 28'd1;
            pad_cnt_d  = pad_wrap  ? 28'd0 : pad_cnt_q + 28'd1;
        end
        // a tick coinciding with its own grant is a fresh tick, not a merge
        ball_pend_d = run && ((ball_pend_q && !ball_grant) || ball_tick);
        pad_pend_d  = run && ((pad_pend_q && !pad_grant) || pad_tick);
        ball_ovr    = ball_tick && ball_pend_q && !ball_grant;
        pad_ovr     = pad_tick && pad_pend_q && !pad_grant;
        ovr_sum     = {1'b0, overrun_q} + {8'd0, ball_ovr} + {8'd0, pad_ovr};
        overrun_d   = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

        hit_cnt_d = hit_cnt_q;
        level_d   = level_q;
        if (miss) begin
            hit_cnt_d = '0;
            level_d   = '0;
        end else if (hit) begin
            if (hit_cnt_q == HC_LAST) begin
                hit_cnt_d = '0;
                if (!at_speed_cap(level_q))
                    level_d = level_q + 4'd1;
            end else begin
                hit_cnt_d = hit_cnt_q + HC_W'(1);
            end
        end
        cur_div_d = div_for_level(level_q);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            ball_cnt_q  <= '0;
            pad_cnt_q   <= '0;
            ball_pend_q <= 1'b0;
            pad_pend_q  <= 1'b0;
            overrun_q   <= '0;
            hit_cnt_q   <= '0;
            level_q     <= '0;
            cur_div_q   <= 28'(BASE_DIV);
        end else begin
            ball_cnt_q  <= ball_cnt_d;
            pad_cnt_q   <= pad_cnt_d;
            ball_pend_q <= ball_pend_d;
            pad_pend_q  <= pad_pend_d;
            overrun_q   <= overrun_d;
            hit_cnt_q   <= hit_cnt_d;
            level_q     <= level_d;
            cur_div_q   <= cur_div_d;
        end
    end

    // A WAIT state with its req already low is the one-cycle drain after an ack.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q       <= IDLE;
            ball_req_q    <= 1'b0;
            pad_req_q     <= 1'b0;
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (ball_pend_q) begin
                        ball_req_q <= 1'b1;
                        state_q    <= BALL_WAIT;
                    end else if (pad_pend_q) begin
                        pad_req_q <= 1'b1;
                        state_q   <= PAD_WAIT;
                    end
                end
                BALL_WAIT: begin
                    if (!ball_req_q) begin
                        state_q <= IDLE;
                    end else if (eng.ball_ack) begin
                        ball_req_q <= 1'b0;
                    end else if (tmo_q == TMO_LAST) begin
                        ball_req_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                PAD_WAIT: begin
                    if (!pad_req_q) begin
                        state_q <= IDLE;
                    end else if (eng.pad_ack) begin
                        pad_req_q <= 1'b0;
                    end else if (tmo_q == TMO_LAST) begin
                        pad_req_q     <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ball_req_q <= 1'b0;
                    pad_req_q  <= 1'b0;
                end
            endcase
        end
    end

    assign eng.ball_req = ball_req_q;
    assign eng.pad_req  = pad_req_q;
    assign busy         = ball_req_q | pad_req_q;
    assign speed_level  = level_q;
    assign cur_div      = cur_div_q;
    assign overrun_cnt  = overrun_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pong_tick_sched.sv
// Bench for pong_tick_sched: two instances (timeout 15 and 40) driven by a
// simple engine model that acks one cycle after a request when enabled.
module tb_pong_tick_sched;
    logic clk = 1'b0;
    logic reset, run_a, run_b, hit, miss;
    logic a_ball_en = 1'b0, a_pad_en = 1'b0, b_ball_en = 1'b0, b_pad_en = 1'b0;
    logic        busy_a, terr_a, busy_b, terr_b;
    logic [3:0]  lvl_a, lvl_b;
    logic [27:0] div_a, div_b;
    logic [7:0]  ovr_a, ovr_b;
    int total = 0;
    int bad = 0;

    pong_tick_sched_if ifa ();
    pong_tick_sched_if ifb ();

    pong_tick_sched #(.BASE_DIV(20), .DIV_STEP(4), .MIN_DIV(8), .HITS_PER_LEVEL(2),
                      .PADDLE_DIV(10), .TIMEOUT(15)) dut_a (
        .clock_in(clk), .reset(reset), .run(run_a), .hit(hit), .miss(miss), .eng(ifa),
        .busy(busy_a), .speed_level(lvl_a), .cur_div(div_a), .overrun_cnt(ovr_a),
        .timeout_err(terr_a));

    pong_tick_sched #(.BASE_DIV(20), .DIV_STEP(4), .MIN_DIV(8), .HITS_PER_LEVEL(2),
                      .PADDLE_DIV(10), .TIMEOUT(40)) dut_b (
        .clock_in(clk), .reset(reset), .run(run_b), .hit(hit), .miss(miss), .eng(ifb),
        .busy(busy_b), .speed_level(lvl_b), .cur_div(div_b), .overrun_cnt(ovr_b),
        .timeout_err(terr_b));

    always #5 clk = ~clk;

    // engine model: ack is raised the cycle after it sees a request
    always @(posedge clk) begin
        #2;
        ifa.ball_ack = ifa.ball_req && a_ball_en;
        ifa.pad_ack  = ifa.pad_req && a_pad_en;
        ifb.ball_ack = ifb.ball_req && b_ball_en;
        ifb.pad_ack  = ifb.pad_req && b_pad_en;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run_a = 1'b0; run_b = 1'b0; hit = 1'b0; miss = 1'b0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({ifa.ball_req, ifa.pad_req, busy_a, lvl_a, div_a, ovr_a, terr_a} !==
            {1'b0, 1'b0, 1'b0, 4'd0, 28'd20, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_a got req=%b%b busy=%b lvl=%0d div=%0d ovr=%0d terr=%b exp 00 0 0 20 0 0",
                     ifa.ball_req, ifa.pad_req, busy_a, lvl_a, div_a, ovr_a, terr_a);
        end
        total++;
        if ({ifb.ball_req, ifb.pad_req, busy_b, lvl_b, div_b, ovr_b, terr_b} !==
            {1'b0, 1'b0, 1'b0, 4'd0, 28'd20, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_b got lvl=%0d div=%0d ovr=%0d terr=%b exp 0 20 0 0",
                     lvl_b, div_b, ovr_b, terr_b);
        end
    endtask

    task automatic test_periods();
        int eb[$];
        int ep[$];
        int e;
        logic pb, pp, expb;
        do_reset();
        a_ball_en = 1'b1; a_pad_en = 1'b1; run_a = 1'b1;
        eb.push_back(21); eb.push_back(41); eb.push_back(61);
        ep.push_back(11); ep.push_back(24); ep.push_back(31);
        ep.push_back(44); ep.push_back(51); ep.push_back(64);
        pb = 1'b0; pp = 1'b0;
        for (int c = 1; c <= 65; c++) begin
            step();
            if (ifa.ball_req && !pb) begin
                e = -1;
                if (eb.size() > 0) e = eb.pop_front();
                total++;
                if (c != e) begin bad++; $display("FAIL periods_ball_rise got cycle %0d exp %0d", c, e); end
            end
            if (ifa.pad_req && !pp) begin
                e = -1;
                if (ep.size() > 0) e = ep.pop_front();
                total++;
                if (c != e) begin bad++; $display("FAIL periods_pad_rise got cycle %0d exp %0d", c, e); end
            end
            if (c == 21 || c == 23) begin
                expb = (c == 21);
                total++;
                if (busy_a !== expb) begin bad++; $display("FAIL periods_busy cycle %0d got %b exp %b", c, busy_a, expb); end
            end
            pb = ifa.ball_req; pp = ifa.pad_req;
        end
        total++;
        if (eb.size() + ep.size() != 0) begin
            bad++; $display("FAIL periods_missing_rises got %0d outstanding exp 0", eb.size() + ep.size());
        end
        total++;
        if ({lvl_a, div_a, ovr_a, terr_a} !== {4'd0, 28'd20, 8'd0, 1'b0}) begin
            bad++; $display("FAIL periods_status got lvl=%0d div=%0d ovr=%0d terr=%b exp 0 20 0 0", lvl_a, div_a, ovr_a, terr_a);
        end
        run_a = 1'b0;
    endtask

    task automatic test_timeout();
        int eb[$];
        int ep[$];
        int e;
        logic pb, pp;
        do_reset();
        a_ball_en = 1'b0; a_pad_en = 1'b0; run_a = 1'b1;
        ep.push_back(11); eb.push_back(27); ep.push_back(30);
        pb = 1'b0; pp = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            step();
            if (c == 26) begin a_ball_en = 1'b1; a_pad_en = 1'b1; end
            if (ifa.ball_req && !pb) begin
                e = -1;
                if (eb.size() > 0) e = eb.pop_front();
                total++;
                if (c != e) begin bad++; $display("FAIL timeout_ball_rise got cycle %0d exp %0d", c, e); end
            end
            if (ifa.pad_req && !pp) begin
                e = -1;
                if (ep.size() > 0) e = ep.pop_front();
                total++;
                if (c != e) begin bad++; $display("FAIL timeout_pad_rise got cycle %0d exp %0d", c, e); end
            end
            if (c == 25) begin
                total++;
                if ({ifa.pad_req, terr_a} !== 2'b10) begin bad++; $display("FAIL timeout_before got req,err=%b%b exp 10", ifa.pad_req, terr_a); end
            end
            if (c == 26) begin
                total++;
                if ({ifa.pad_req, terr_a} !== 2'b01) begin bad++; $display("FAIL timeout_fire got req,err=%b%b exp 01", ifa.pad_req, terr_a); end
            end
            pb = ifa.ball_req; pp = ifa.pad_req;
        end
        total++;
        if (eb.size() + ep.size() != 0) begin
            bad++; $display("FAIL timeout_missing_rises got %0d outstanding exp 0", eb.size() + ep.size());
        end
        repeat (10) step();
        total++;
        if (terr_a !== 1'b1) begin bad++; $display("FAIL timeout_sticky got %b exp 1", terr_a); end
        reset = 1'b1;
        step();
        reset = 1'b0; run_a = 1'b0;
        total++;
        if ({terr_a, busy_a} !== 2'b00) begin bad++; $display("FAIL timeout_cleared got err,busy=%b%b exp 00", terr_a, busy_a); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_ball_en = 1'b0; a_pad_en = 1'b0; run_a = 1'b1;
        repeat (13) step();
        total++;
        if ({ifa.pad_req, busy_a} !== 2'b11) begin bad++; $display("FAIL resetmid_inflight got req,busy=%b%b exp 11", ifa.pad_req, busy_a); end
        reset = 1'b1;
        step();
        total++;
        if ({ifa.ball_req, ifa.pad_req, busy_a} !== 3'b000) begin
            bad++; $display("FAIL resetmid_drop got %b%b%b exp 000", ifa.ball_req, ifa.pad_req, busy_a);
        end
        reset = 1'b0; run_a = 1'b0;
    endtask

    task automatic test_speed();
        int lvl_tab[8] = '{0, 1, 1, 2, 2, 3, 3, 3};
        int div_tab[8] = '{20, 16, 16, 12, 12, 8, 8, 8};
        int lq[$];
        int dq[$];
        int prev_div, e;
        do_reset();
        prev_div = 20;
        for (int i = 0; i < 8; i++) begin
            lq.push_back(lvl_tab[i]); dq.push_back(div_tab[i]);
            hit = 1'b1;
            step();
            hit = 1'b0;
            e = lq.pop_front();
            total++;
            if (int'(lvl_a) != e) begin bad++; $display("FAIL speed_level hit %0d got %0d exp %0d", i + 1, lvl_a, e); end
            total++;
            if (int'(div_a) != prev_div) begin bad++; $display("FAIL speed_div_lag hit %0d got %0d exp %0d", i + 1, div_a, prev_div); end
            step();
            e = dq.pop_front();
            total++;
            if (int'(div_a) != e) begin bad++; $display("FAIL speed_div hit %0d got %0d exp %0d", i + 1, div_a, e); end
            prev_div = e;
        end
        miss = 1'b1;
        step();
        miss = 1'b0;
        total++;
        if (lvl_a !== 4'd0) begin bad++; $display("FAIL speed_miss_level got %0d exp 0", lvl_a); end
        step();
        total++;
        if (div_a !== 28'd20) begin bad++; $display("FAIL speed_miss_div got %0d exp 20", div_a); end
    endtask

    task automatic test_hit_miss();
        do_reset();
        hit = 1'b1; step(); hit = 1'b0;
        total++;
        if (lvl_a !== 4'd0) begin bad++; $display("FAIL hitmiss_first got %0d exp 0", lvl_a); end
        hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
        total++;
        if (lvl_a !== 4'd0) begin bad++; $display("FAIL hitmiss_same_cycle got %0d exp 0", lvl_a); end
        hit = 1'b1; step(); hit = 1'b0;
        total++;
        if (lvl_a !== 4'd0) begin bad++; $display("FAIL hitmiss_count_cleared got %0d exp 0", lvl_a); end
        hit = 1'b1; step(); hit = 1'b0;
        total++;
        if (lvl_a !== 4'd1) begin bad++; $display("FAIL hitmiss_after got %0d exp 1", lvl_a); end
    endtask

    task automatic test_div_change();
        int eb[$];
        int e;
        logic pb;
        do_reset();
        a_ball_en = 1'b1; a_pad_en = 1'b1; run_a = 1'b1;
        eb.push_back(20); eb.push_back(36);
        pb = 1'b0;
        for (int c = 1; c <= 37; c++) begin
            step();
            if (c == 15) hit = 1'b1;
            if (c == 17) hit = 1'b0;
            if (c == 18) begin
                total++;
                if (div_a !== 28'd16) begin bad++; $display("FAIL divchg_cur_div got %0d exp 16", div_a); end
            end
            if (ifa.ball_req && !pb) begin
                e = -1;
                if (eb.size() > 0) e = eb.pop_front();
                total++;
                if (c != e) begin bad++; $display("FAIL divchg_ball_rise got cycle %0d exp %0d", c, e); end
            end
            pb = ifa.ball_req;
        end
        total++;
        if (eb.size() != 0) begin bad++; $display("FAIL divchg_missing_rises got %0d exp 0", eb.size()); end
        run_a = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        b_ball_en = 1'b1; b_pad_en = 1'b0; run_b = 1'b1;
        for (int c = 1; c <= 66; c++) begin
            step();
            if (c == 29 || c == 30 || c == 40) begin
                total++;
                if (int'(ovr_b) != ((c == 29) ? 0 : (c == 30) ? 1 : 3)) begin
                    bad++; $display("FAIL overrun_count cycle %0d got %0d exp %0d", c, ovr_b, (c == 29) ? 0 : (c == 30) ? 1 : 3);
                end
            end
            if (c == 45) begin
                total++;
                if ({ifb.ball_req, ifb.pad_req, terr_b, ovr_b} !== {1'b0, 1'b1, 1'b0, 8'd3}) begin
                    bad++; $display("FAIL overrun_wait got req=%b%b err=%b ovr=%0d exp 01 0 3", ifb.ball_req, ifb.pad_req, terr_b, ovr_b);
                end
                run_b = 1'b0;
            end
            if (c == 47) begin
                total++;
                if (ifb.pad_req !== 1'b1) begin bad++; $display("FAIL pause_inflight got %b exp 1", ifb.pad_req); end
                b_pad_en = 1'b1;
            end
            if (c == 48) begin
                total++;
                if (ifb.pad_req !== 1'b0) begin bad++; $display("FAIL pause_complete got %b exp 0", ifb.pad_req); end
            end
            if (c == 55) begin
                total++;
                if ({ifb.ball_req, ifb.pad_req, busy_b, ovr_b} !== {3'b000, 8'd3}) begin
                    bad++; $display("FAIL pause_quiet got req=%b%b busy=%b ovr=%0d exp 00 0 3", ifb.ball_req, ifb.pad_req, busy_b, ovr_b);
                end
                run_b = 1'b1;
            end
            if (c == 65 || c == 66) begin
                total++;
                if (ifb.pad_req !== (c == 66)) begin bad++; $display("FAIL resume_pad cycle %0d got %b exp %b", c, ifb.pad_req, c == 66); end
            end
        end
        run_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_periods();
        test_timeout();
        test_reset_mid();
        test_speed();
        test_hit_miss();
        test_div_change();
        test_overrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end
endmodule

// File: doc/pong_tick_sched.md
Name: pong_tick_sched

Overview:
- Replaces the fixed-rate ball clock with a single-clock-domain scheduler for the pong update engine.
- Generates ball and paddle update ticks from programmable dividers.
- Arbitrates the two ticks onto one shared object-update engine through req/ack handshakes.
- Raises ball speed (shrinks the ball divisor) as paddle hits accumulate; restores base speed on a miss.

Parameters:
- BASE_DIV, 800000: ball tick period in clocks at level 0.
- DIV_STEP, 50000: ball period reduction per speed level.
- MIN_DIV, 200000: floor for the ball period.
- HITS_PER_LEVEL, 4: paddle hits needed per level increment.
- PADDLE_DIV, 400000: fixed paddle tick period in clocks.
- TIMEOUT, 1023: maximum clocks a req may wait for its ack.

Ports:
- clock_in  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- run  in  1  game running; 0 = paused.
- hit  in  1  one-cycle pulse: ball struck a paddle.
- miss  in  1  one-cycle pulse: point scored.
- ball_req  out  1  ball update request to the engine.
- ball_ack  in  1  engine finished the ball update.
- pad_req  out  1  paddle update request to the engine.
- pad_ack  in  1  engine finished the paddle update.
- busy  out  1  a request is outstanding.
- speed_level  out  4  current speed level.
- cur_div  out  28  active ball period.
- overrun_cnt  out  8  ticks merged into an already-pending tick; saturates at 255.
- timeout_err  out  1  sticky: an ack timed out.

Behaviour:
- Reset values: all outputs 0 except cur_div=BASE_DIV. Tick counters, pending flags, hit counter and timeout counter are also cleared.
- Ball divider:
  - Counter increments every clock while run=1; at count >= cur_div-1 it wraps to 0 and sets ball_pend.
  - A cur_div change takes effect immediately. If the new cur_div-1 <= count, the counter wraps on the next clock (one tick, no lost tick).
- Paddle divider: same rule with PADDLE_DIV; sets pad_pend.
- A tick arriving while its pending flag is already 1 is merged (flag stays 1) and increments overrun_cnt.
- Pause: run=0 holds both counters at 0 and clears both pending flags. A handshake already in flight completes normally.
- FSM states: IDLE, BALL_WAIT, PAD_WAIT.
  - IDLE: if ball_pend, assert ball_req, clear ball_pend, go to BALL_WAIT. Else if pad_pend, assert pad_req, clear pad_pend, go to PAD_WAIT. Ball has fixed priority.
  - BALL_WAIT / PAD_WAIT: req is held high until the matching ack is sampled high. req drops the next cycle, then return to IDLE. Minimum 3 clocks from IDLE to the next req.
  - Acks are ignored in other states, and an ack for the non-requested channel is ignored.
  - busy = ball_req | pad_req.
- Timeout: a counter runs in either WAIT state. On reaching TIMEOUT with no ack: drop req, set timeout_err (cleared only by reset), return to IDLE. The dropped update is not retried.
- Speed control:
  - hit increments hit_cnt. When hit_cnt reaches HITS_PER_LEVEL, it resets to 0 and speed_level increments, saturating at 15 or at the first level where BASE_DIV - level*DIV_STEP <= MIN_DIV.
  - cur_div = max(BASE_DIV - speed_level*DIV_STEP, MIN_DIV), registered, updating one cycle after speed_level.
  - miss clears hit_cnt and speed_level. If miss and hit arrive in the same cycle, miss wins.
- Reset mid-handshake: req drops on the next clock; no ack is expected afterwards.

Test Plan:
Use BASE_DIV=20, DIV_STEP=4, MIN_DIV=8, HITS_PER_LEVEL=2, PADDLE_DIV=10, TIMEOUT=15.
- Reset, run=1, engine acks 1 cycle after req -> ball_req rises every 20 clocks and pad_req every 10; speed_level=0, cur_div=20.
- Ball and paddle ticks on the same clock -> ball_req first; pad_req asserts 3 clocks after ball_ack; overrun_cnt=0.
- Engine holds acks low for 25 clocks -> req drops after 15 clocks, timeout_err=1 and stays 1 until reset; next tick is issued normally.
- Six hit pulses -> speed_level 1,2,3 after hits 2,4,6; cur_div 16,12,8. Two more hits -> level stays 3, cur_div=8. Then miss -> level 0, cur_div=20.
- hit and miss in the same cycle with hit_cnt=1 -> hit_cnt=0, level=0.
- Engine never acks paddle within 2 PADDLE_DIV periods (TIMEOUT raised to 40) -> overrun_cnt increments once per merged paddle tick. run=0 mid-wait -> handshake completes, counters held at 0, no new req.
